mem_stage_mmio: RTL

- MEM-stage data-memory block of the 5-stage MIPS pipeline.
- Consumes EX/MEM outputs (ALU result as address, rt data, MemRead/MemWrite) and returns read data for the MEM/WB register's MemData input.
- Contains the word-addressed data RAM and the memory-mapped peripherals: interval timer with interrupt, LED register, 7-seg digit register, and a free-running systick counter.

---
 rtl/mem_stage_mmio_pkg.sv | 18 +
 rtl/mem_stage_mmio_if.sv | 11 +
 rtl/mem_stage_mmio_timer.sv | 79 +++++++
 rtl/mem_stage_mmio.sv | 117 +++++++++++
 4 files changed

// File: rtl/mem_stage_mmio_pkg.sv
// Shared constants for the MEM-stage data memory and its peripheral window:
// register offsets, timer control bit positions and the default window base.
package mem_stage_mmio_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h4000_0000;

  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_DIGITS  = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

endpackage

// File: rtl/mem_stage_mmio_if.sv
// Load/store bus between the EX/MEM register and the data-memory block.
interface mem_stage_mmio_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output mem_read, output mem_write, output addr, output write_data, input read_data);
  modport slave  (input mem_read, input mem_write, input addr, input write_data, output read_data);
endinterface

// File: rtl/mem_stage_mmio_timer.sv
// Interval timer: TL counts up while enabled and reloads from TH after
// 32'hFFFF_FFFF; the status bit latches the overflow and drives a registered irq.
module mmio_timer
  import mem_stage_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        th_we,
  input  logic        tl_we,
  input  logic        tcon_we,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        irq_q, irq_d;
  logic        overflow_s;

  // Next-state: a CPU write beats the count; the status bit never drops a pending overflow.
  always_comb begin
    overflow_s = tcon_q[TCON_EN] & (tl_q == 32'hFFFF_FFFF);
    th_d       = th_q;
    tl_d       = tl_q;
    tcon_d     = tcon_q;
    irq_d      = tcon_q[TCON_IE] & tcon_q[TCON_IS];

    if (th_we) begin
      th_d = wdata;
    end else begin
      th_d = th_q;
    end

    if (tl_we) begin
      tl_d = wdata;
    end else if (overflow_s) begin
      tl_d = th_q;
    end else if (tcon_q[TCON_EN]) begin
      tl_d = tl_q + 32'd1;
    end else begin
      tl_d = tl_q;
    end

    if (tcon_we) begin
      tcon_d[TCON_EN] = wdata[TCON_EN];
      tcon_d[TCON_IE] = wdata[TCON_IE];
      tcon_d[TCON_IS] = wdata[TCON_IS] | (overflow_s & wdata[TCON_IE]);
    end else if (overflow_s & tcon_q[TCON_IE]) begin
      tcon_d[TCON_IS] = 1'b1;
    end else begin
      tcon_d = tcon_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= 32'd0;
      tl_q   <= 32'd0;
      tcon_q <= 3'd0;
      irq_q  <= 1'b0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      irq_q  <= irq_d;
    end
  end

  assign th   = th_q;
  assign tl   = tl_q;
  assign tcon = tcon_q;
  assign irq  = irq_q;

endmodule

// File: rtl/mem_stage_mmio.sv
// MEM-stage data memory: word-addressed RAM plus the peripheral window
// (timer, LEDs, 7-seg digits, systick); loads are combinational.
module mem_stage_mmio
  import mem_stage_mmio_pkg::*;
#(
  parameter int          RAM_WORDS = 512,
  parameter int          RAM_AW    = 9,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_stage_mmio_if.slave        bus,
  output logic [7:0]             leds,
  output logic [11:0]            digits,
  output logic                   irq
);

  logic [31:0]       mem_q [RAM_WORDS];
  logic [7:0]        led_q, led_d;
  logic [11:0]       digits_q, digits_d;
  logic [31:0]       systick_q, systick_d;
  logic              ram_sel_s, mmio_sel_s, ram_we_s;
  logic [RAM_AW-1:0] ram_idx_s;
  logic [4:0]        off_s;
  logic              th_we_s, tl_we_s, tcon_we_s;
  logic [31:0]       th_s, tl_s;
  logic [2:0]        tcon_s;
  logic              unused_addr_s;

  // Byte-lane bits are ignored: every access targets the containing word.
  assign ram_sel_s     = (bus.addr[31:RAM_AW+2] == '0);
  assign mmio_sel_s    = (bus.addr[31:5] == MMIO_BASE[31:5]);
  assign ram_idx_s     = bus.addr[RAM_AW+1:2];
  assign off_s         = {bus.addr[4:2], 2'b00};
  assign unused_addr_s = ^bus.addr[1:0];

  assign ram_we_s  = bus.mem_write & ram_sel_s & ~reset;
  assign th_we_s   = bus.mem_write & mmio_sel_s & (off_s == OFF_TH);
  assign tl_we_s   = bus.mem_write & mmio_sel_s & (off_s == OFF_TL);
  assign tcon_we_s = bus.mem_write & mmio_sel_s & (off_s == OFF_TCON);

  mmio_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .th_we   (th_we_s),
    .tl_we   (tl_we_s),
    .tcon_we (tcon_we_s),
    .wdata   (bus.write_data),
    .th      (th_s),
    .tl      (tl_s),
    .tcon    (tcon_s),
    .irq     (irq)
  );

  // Load mux; reads see register state before any same-cycle store.
  always_comb begin
    bus.read_data = 32'd0;
    if (!bus.mem_read) begin
      bus.read_data = 32'd0;
    end else if (ram_sel_s) begin
      bus.read_data = mem_q[ram_idx_s];
    end else if (mmio_sel_s) begin
      case (off_s)
        OFF_TH:      bus.read_data = th_s;
        OFF_TL:      bus.read_data = tl_s;
        OFF_TCON:    bus.read_data = {29'd0, tcon_s};
        OFF_LED:     bus.read_data = {24'd0, led_q};
        OFF_DIGITS:  bus.read_data = {20'd0, digits_q};
        OFF_SYSTICK: bus.read_data = systick_q;
        default:     bus.read_data = 32'd0;
      endcase
    end else begin
      bus.read_data = 32'd0;
    end
  end

  // Output registers and systick next-state.
  always_comb begin
    led_d     = led_q;
    digits_d  = digits_q;
    systick_d = systick_q + 32'd1;
    if (bus.mem_write && mmio_sel_s && off_s == OFF_LED) begin
      led_d = bus.write_data[7:0];
    end else begin
      led_d = led_q;
    end
    if (bus.mem_write && mmio_sel_s && off_s == OFF_DIGITS) begin
      digits_d = bus.write_data[11:0];
    end else begin
      digits_d = digits_q;
    end
  end

  // Peripheral registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= 8'd0;
      digits_q  <= 12'd0;
      systick_q <= 32'd0;
    end else begin
      led_q     <= led_d;
      digits_q  <= digits_d;
      systick_q <= systick_d;
    end
  end

  // Data RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_q[ram_idx_s] <= bus.write_data;
    end
  end

  assign leds   = led_q;
  assign digits = digits_q;

endmodule
